talk_arbiter: RTL and testbench

- Shares the single speech player (start_talk / word_code / talk_done handshake) between NUM_REQ word requesters, e.g. the calculator FSM and a keypad-echo or status announcer.
- Grants requesters round-robin, holds the selected word code stable while the word plays, and enforces a silent gap between words.
- Aborts words whose talk_done never arrives, using a watchdog.
- Sits between the requesting FSMs and the speech player; requesters never drive start_talk directly.

---
 rtl/talk_arbiter.sv | 117 +++++++++++
 tb/tb_talk_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/talk_arbiter.sv
// rtl/talk_arbiter.sv - round-robin arbiter sharing one speech player between word requesters

module talk_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_word,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     done,
    output logic                   timeout,
    input  logic                   talk_done,
    output logic                   start_talk,
    output logic [7:0]             word_code,
    output logic                   busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_TALK, S_SKIP, S_GAP} state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     last_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [NUM_REQ-1:0]   done_q;
    logic                 timeout_q;
    logic [7:0]           word_q;
    logic [WD_W-1:0]      wd_q;
    logic [GAP_W-1:0]     gap_q;

    logic [IDX_W-1:0]     win_idx_d;
    logic [IDX_W-1:0]     cand_d;
    logic [7:0]           win_word_d;
    logic                 gap_last_d;

    // Scan from farthest to nearest so the nearest requester after last_q wins.
    always_comb begin
        win_idx_d = last_q;
        cand_d    = last_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_d = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (req[cand_d]) begin
                win_idx_d = cand_d;
            end
        end
        win_word_d = req_word[{win_idx_d, 3'b000} +: 8];
        gap_last_d = (GAP_CYCLES <= 1) || (gap_q == GAP_W'(GAP_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            last_q    <= IDX_W'(NUM_REQ - 1);
            ack_q     <= '0;
            done_q    <= '0;
            timeout_q <= 1'b0;
            word_q    <= 8'h00;
            wd_q      <= '0;
            gap_q     <= '0;
        end else begin
            ack_q     <= '0;
            done_q    <= '0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        word_q  <= win_word_d;
                        ack_q   <= NUM_REQ'(1) << win_idx_d;
                        last_q  <= win_idx_d;
                        wd_q    <= '0;
                        state_q <= (win_word_d == 8'h00) ? S_SKIP : S_TALK;
                    end
                end
                S_TALK: begin
                    if (talk_done) begin
                        done_q  <= NUM_REQ'(1) << last_q;
                        gap_q   <= '0;
                        state_q <= S_GAP;
                    end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        done_q    <= NUM_REQ'(1) << last_q;
                        timeout_q <= 1'b1;
                        gap_q     <= '0;
                        state_q   <= S_GAP;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                S_SKIP: begin
                    done_q  <= NUM_REQ'(1) << last_q;
                    gap_q   <= '0;
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    if (gap_last_d) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack        = ack_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign word_code  = word_q;
    assign start_talk = (state_q == S_TALK);
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_talk_arbiter.sv
// tb/tb_talk_arbiter.sv - table-driven and directed checks for talk_arbiter

module tb_talk_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] req_word;
    logic        talk_done;

    logic [1:0]  ack_a, done_a, ack_b, done_b;
    logic        to_a, st_a, busy_a, to_b, st_b, busy_b;
    logic [7:0]  wc_a, wc_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    talk_arbiter #(.NUM_REQ(2), .GAP_CYCLES(4), .TIMEOUT_CYCLES(20)) dut_a (
        .clk(clk), .reset(reset), .req(req), .req_word(req_word),
        .ack(ack_a), .done(done_a), .timeout(to_a), .talk_done(talk_done),
        .start_talk(st_a), .word_code(wc_a), .busy(busy_a)
    );

    talk_arbiter #(.NUM_REQ(2), .GAP_CYCLES(0), .TIMEOUT_CYCLES(20)) dut_b (
        .clk(clk), .reset(reset), .req(req), .req_word(req_word),
        .ack(ack_b), .done(done_b), .timeout(to_b), .talk_done(talk_done),
        .start_talk(st_b), .word_code(wc_b), .busy(busy_b)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [15:0] word;
        logic        td;
        logic [1:0]  ack;
        logic [1:0]  done;
        logic        to;
        logic        st;
        logic [7:0]  wc;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [1:0] r, input logic [15:0] w,
                       input logic td, input logic [1:0] a, input logic [1:0] d,
                       input logic to, input logic st, input logic [7:0] wc, input logic b);
        vec_t v;
        v.rst = rst; v.req = r; v.word = w; v.td = td; v.ack = a; v.done = d;
        v.to = to; v.st = st; v.wc = wc; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a(input string name);
        int n;
        n = 0;
        while (busy_a && n < 200) begin
            cyc();
            n++;
        end
        check(name, 32'(busy_a), 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int cyc_no;
        int ack_cyc[$];
        logic [1:0] ack_val[$];
        logic [7:0] ack_wc[$];
        int bad_acks;
        logic [1:0] a;
        logic [7:0] w;

        reset = 1'b1; req = '0; req_word = '0; talk_done = 1'b0;

        // single request, 11-cycle word
        add(1, 2'b00, 16'h0000, 0, 2'b00, 2'b00, 0, 0, 8'h00, 0);
        add(0, 2'b01, 16'h0005, 0, 2'b01, 2'b00, 0, 1, 8'h05, 1);
        for (int k = 0; k < 10; k++) add(0, 2'b00, 16'h0005, 0, 2'b00, 2'b00, 0, 1, 8'h05, 1);
        add(0, 2'b00, 16'h0005, 1, 2'b00, 2'b01, 0, 0, 8'h05, 1);
        for (int k = 0; k < 3; k++) add(0, 2'b00, 16'h0005, 0, 2'b00, 2'b00, 0, 0, 8'h05, 1);
        add(0, 2'b00, 16'h0005, 0, 2'b00, 2'b00, 0, 0, 8'h05, 0);
        // silent word from requester 1
        add(0, 2'b10, 16'h0000, 0, 2'b10, 2'b00, 0, 0, 8'h00, 1);
        add(0, 2'b00, 16'h0000, 0, 2'b00, 2'b10, 0, 0, 8'h00, 1);
        for (int k = 0; k < 3; k++) add(0, 2'b00, 16'h0000, 0, 2'b00, 2'b00, 0, 0, 8'h00, 1);
        add(0, 2'b00, 16'h0000, 0, 2'b00, 2'b00, 0, 0, 8'h00, 0);
        // contention: grants alternate 0,1,0,1; talk_done in GAP is ignored
        for (int g = 0; g < 4; g++) begin
            a = (g % 2 == 1) ? 2'b10 : 2'b01;
            w = (g % 2 == 1) ? 8'h03 : 8'h02;
            add(0, 2'b11, 16'h0302, 0, a, 2'b00, 0, 1, w, 1);
            add(0, 2'b11, 16'h0302, 1, 2'b00, a, 0, 0, w, 1);
            add(0, 2'b11, 16'h0302, 1, 2'b00, 2'b00, 0, 0, w, 1);
            for (int k = 0; k < 2; k++) add(0, 2'b11, 16'h0302, 0, 2'b00, 2'b00, 0, 0, w, 1);
            add(0, 2'b11, 16'h0302, 0, 2'b00, 2'b00, 0, 0, w, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; req = vecs[i].req; req_word = vecs[i].word; talk_done = vecs[i].td;
            cyc();
            check($sformatf("vec%0d_ack", i), 32'(ack_a), 32'(vecs[i].ack));
            check($sformatf("vec%0d_done", i), 32'(done_a), 32'(vecs[i].done));
            check($sformatf("vec%0d_timeout", i), 32'(to_a), 32'(vecs[i].to));
            check($sformatf("vec%0d_start_talk", i), 32'(st_a), 32'(vecs[i].st));
            check($sformatf("vec%0d_word_code", i), 32'(wc_a), 32'(vecs[i].wc));
            check($sformatf("vec%0d_busy", i), 32'(busy_a), 32'(vecs[i].busy));
        end
        req = 2'b00; talk_done = 1'b0;

        // watchdog expiry: start_talk high exactly 20 cycles
        req = 2'b01; req_word = 16'h0007;
        cyc();
        check("to_ack", 32'(ack_a), 32'h1);
        req = 2'b00;
        n = 1;
        while (st_a && n < 100) begin
            cyc();
            if (st_a) n++;
        end
        check("to_len", 32'(n), 32'd20);
        check("to_done", 32'(done_a), 32'h1);
        check("to_pulse", 32'(to_a), 32'h1);
        check("to_gap_busy", 32'(busy_a), 32'h1);
        cyc();
        check("to_pulse_width", 32'(to_a), 32'h0);
        wait_idle_a("to_idle");

        // talk_done on the last watchdog cycle wins over timeout
        req = 2'b01;
        cyc();
        req = 2'b00;
        n = 1;
        while (n < 20) begin
            cyc();
            if (st_a) n++;
            else n = 100;
        end
        check("race_still_talking", 32'(st_a), 32'h1);
        talk_done = 1'b1;
        cyc();
        talk_done = 1'b0;
        check("race_done", 32'(done_a), 32'h1);
        check("race_no_timeout", 32'(to_a), 32'h0);
        wait_idle_a("race_idle");

        // reset mid-TALK with requester 1 pending
        req = 2'b01; req_word = 16'h0A09;
        cyc();
        check("rst_ack0", 32'(ack_a), 32'h1);
        check("rst_wc0", 32'(wc_a), 32'h09);
        req = 2'b10;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        check("rst_start", 32'(st_a), 32'h0);
        check("rst_wc", 32'(wc_a), 32'h00);
        check("rst_done", 32'(done_a), 32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
        reset = 1'b0;
        cyc();
        check("rst_regrant_ack", 32'(ack_a), 32'h2);
        check("rst_regrant_wc", 32'(wc_a), 32'h0A);
        check("rst_regrant_st", 32'(st_a), 32'h1);
        req = 2'b00; talk_done = 1'b1;
        cyc();
        talk_done = 1'b0;

        // GAP_CYCLES=0: back-to-back words three cycles apart
        reset = 1'b1;
        cyc();
        reset = 1'b0; req = 2'b11; req_word = 16'h2221; talk_done = 1'b1;
        for (cyc_no = 1; cyc_no <= 13; cyc_no++) begin
            cyc();
            if (ack_b != 2'b00) begin
                ack_cyc.push_back(cyc_no);
                ack_val.push_back(ack_b);
                ack_wc.push_back(wc_b);
            end
        end
        check("g0_ack_count", 32'(ack_cyc.size()), 32'd5);
        if (ack_cyc.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("g0_ack%0d_cycle", i), 32'(ack_cyc[i]), 32'(1 + 3 * i));
                check($sformatf("g0_ack%0d_val", i), 32'(ack_val[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
                check($sformatf("g0_ack%0d_wc", i), 32'(ack_wc[i]), (i % 2 == 0) ? 32'h21 : 32'h22);
            end
        end

        // withdrawn request while busy is never acked
        reset = 1'b1; req = 2'b00; talk_done = 1'b0;
        cyc();
        reset = 1'b0; req = 2'b01; req_word = 16'h0011;
        cyc();
        check("wd_ack0", 32'(ack_b), 32'h1);
        req = 2'b10;
        cyc();
        req = 2'b00;
        cyc();
        talk_done = 1'b1;
        cyc();
        talk_done = 1'b0;
        check("wd_done", 32'(done_b), 32'h1);
        check("wd_gap_busy", 32'(busy_b), 32'h1);
        cyc();
        check("wd_gap_one_cycle", 32'(busy_b), 32'h0);
        bad_acks = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (ack_b[1]) bad_acks++;
        end
        check("wd_never_acked", 32'(bad_acks), 32'h0);
        check("wd_idle", 32'(busy_b), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
